// File: rtl/sa_result_collector_pkg.sv
// Shared definitions for the systolic-array result collector: states, defaults, flush length.
// Narrowing mode is selected by SA_COLLECT_SAT_EN (saturate) versus wrap when undefined.
package SA_pkg;

  localparam int SA_D_W   = 8;
  localparam int SA_ACC_W = 24;
  localparam int SA_X_R   = 16;
  localparam int SA_W_C   = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_FEED = 3'd1,
    S_FLUSH     = 3'd2,
    S_DRAIN     = 3'd3,
    S_DONE      = 3'd4
  } sa_state_e;

  // Shift pulses needed after the last input vector for the skewed wavefront to settle.
  function automatic int sa_flush_len(input int x_r, input int w_c);
    return x_r + w_c - 2;
  endfunction

endpackage

// File: rtl/sa_result_collector_sat_trunc.sv
// Per-element narrowing of a signed accumulator to the output width.
// SA_COLLECT_SAT_EN defined: clamp to the D_W signed range; undefined: keep the low D_W bits.
module SA_sat_trunc #(
  parameter int ACC_W = 24,
  parameter int D_W   = 8
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [D_W-1:0]   dat
);

`ifdef SA_COLLECT_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-D_W+1){1'b0}}, {(D_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

  always_comb begin
    if (acc > MAX_V)      dat = MAX_V[D_W-1:0];
    else if (acc < MIN_V) dat = MIN_V[D_W-1:0];
    else                  dat = acc[D_W-1:0];
  end
`else
  logic unused_hi;
  assign unused_hi = ^acc[ACC_W-1:D_W];
  assign dat       = acc[D_W-1:0];
`endif

endmodule

// File: rtl/sa_result_collector.sv
// Collects drained rows of a systolic array into a registered result matrix.
// Narrowing mode follows SA_COLLECT_SAT_EN (see SA_sat_trunc).
//
// state     | meaning
// IDLE      | after reset, waiting for I_START
// WAIT_FEED | armed, waiting for the feeder's last vector
// FLUSH     | counting shift pulses while the skewed wavefront settles
// DRAIN     | requesting drain, capturing rows bottom-first
// DONE      | matrix complete and held until the next I_START
module sa_result_collector import SA_pkg::*; #(
  parameter int D_W   = SA_D_W,
  parameter int ACC_W = SA_ACC_W,
  parameter int X_R   = SA_X_R,
  parameter int W_C   = SA_W_C
) (
  input  logic                    I_CLK,
  input  logic                    I_ASYN_RSTN,
  input  logic                    I_START,
  input  logic                    I_PE_SHIFT,
  input  logic                    I_FEED_OVER,
  input  logic                    I_SA_OUT_VLD,
  input  logic signed [ACC_W-1:0] I_SA_ROW   [0:W_C-1],
  output logic                    O_DRAIN_REQ,
  output logic signed [D_W-1:0]   O_Y_MATRIX [0:X_R-1][0:W_C-1],
  output logic                    O_BUSY,
  output logic                    O_DONE
);

  localparam int FLUSH_LEN = sa_flush_len(X_R, W_C);
  localparam int FW        = $clog2(FLUSH_LEN + 1);
  localparam int RW        = $clog2(X_R + 1);
  localparam int IW        = (X_R > 1) ? $clog2(X_R) : 1;

  sa_state_e             state;
  logic [FW-1:0]         flush_cnt;
  logic [RW-1:0]         row_cnt;
  logic [IW-1:0]         wr_row;
  logic signed [D_W-1:0] row_n [0:W_C-1];
  logic signed [D_W-1:0] y_q   [0:X_R-1][0:W_C-1];

  for (genvar c = 0; c < W_C; c++) begin : g_narrow
    SA_sat_trunc #(.ACC_W(ACC_W), .D_W(D_W)) u_narrow (
      .acc (I_SA_ROW[c]),
      .dat (row_n[c])
    );
  end

  // Rows leave the array bottom row first.
  assign wr_row = IW'(X_R - 1) - row_cnt[IW-1:0];

  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      state     <= S_IDLE;
      flush_cnt <= '0;
      row_cnt   <= '0;
    end else if (I_START) begin
      state     <= S_WAIT_FEED;
      flush_cnt <= '0;
      row_cnt   <= '0;
    end else begin
      case (state)
        S_WAIT_FEED: if (I_FEED_OVER) state <= S_FLUSH;
        S_FLUSH: begin
          if (I_PE_SHIFT) begin
            flush_cnt <= flush_cnt + 1'b1;
            if (flush_cnt == FW'(FLUSH_LEN - 1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (I_SA_OUT_VLD) begin
            row_cnt <= row_cnt + 1'b1;
            if (row_cnt == RW'(X_R - 1)) state <= S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      y_q <= '{default: '0};
    end else if (I_START) begin
      y_q <= '{default: '0};
    end else if (state == S_DRAIN && I_SA_OUT_VLD) begin
      y_q[wr_row] <= row_n;
    end
  end

  assign O_Y_MATRIX  = y_q;
  assign O_DRAIN_REQ = (state == S_DRAIN);
  assign O_DONE      = (state == S_DONE);
  assign O_BUSY      = (state != S_IDLE) && (state != S_DONE);

endmodule

// File: tb/tb_sa_result_collector.sv
// Randomized scoreboard bench for sa_result_collector; honours SA_COLLECT_SAT_EN when defined.
module tb_sa_result_collector;

  localparam int D_W       = 8;
  localparam int ACC_W     = 24;
  localparam int X_R       = 16;
  localparam int W_C       = 16;
  localparam int FLUSH_LEN = X_R + W_C - 2;

`ifdef SA_COLLECT_SAT_EN
  localparam int NARROW_POS = 127;
  localparam int NARROW_NEG = -128;
`else
  localparam int NARROW_POS = 44;
  localparam int NARROW_NEG = 56;
`endif

  logic I_CLK = 1'b0;
  logic I_ASYN_RSTN = 1'b0;
  logic I_START = 1'b0;
  logic I_PE_SHIFT = 1'b0;
  logic I_FEED_OVER = 1'b0;
  logic I_SA_OUT_VLD = 1'b0;
  logic signed [ACC_W-1:0] sa_row [0:W_C-1];
  logic O_DRAIN_REQ, O_BUSY, O_DONE;
  logic signed [D_W-1:0] y [0:X_R-1][0:W_C-1];

  int checks = 0;
  int failures = 0;
  int exp_m [X_R][W_C];
  int exp_q [$];

  always #5 I_CLK = ~I_CLK;

  sa_result_collector dut (
    .I_CLK        (I_CLK),
    .I_ASYN_RSTN  (I_ASYN_RSTN),
    .I_START      (I_START),
    .I_PE_SHIFT   (I_PE_SHIFT),
    .I_FEED_OVER  (I_FEED_OVER),
    .I_SA_OUT_VLD (I_SA_OUT_VLD),
    .I_SA_ROW     (sa_row),
    .O_DRAIN_REQ  (O_DRAIN_REQ),
    .O_Y_MATRIX   (y),
    .O_BUSY       (O_BUSY),
    .O_DONE       (O_DONE)
  );

  // Reference narrowing from the numeric rule, not from bit slicing.
  function automatic int narrow(input int v);
    int m;
`ifdef SA_COLLECT_SAT_EN
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
`else
    m = ((v % 256) + 256) % 256;
    if (m > 127) m = m - 256;
    return m;
`endif
  endfunction

  function automatic int mat_zero();
    for (int r = 0; r < X_R; r++)
      for (int c = 0; c < W_C; c++)
        if (y[r][c] != 0) return 0;
    return 1;
  endfunction

  function automatic int mat_match();
    for (int r = 0; r < X_R; r++)
      for (int c = 0; c < W_C; c++)
        if (int'(y[r][c]) != exp_m[r][c]) return 0;
    return 1;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int rand_acc();
    return int'($urandom_range(0, 140000)) - 70000;
  endfunction

  task automatic junk_row();
    for (int c = 0; c < W_C; c++) sa_row[c] = ACC_W'(rand_acc());
  endtask

  task automatic clear_model();
    for (int r = 0; r < X_R; r++)
      for (int c = 0; c < W_C; c++) exp_m[r][c] = 0;
  endtask

  // Scoreboard monitor: on every rising O_DONE, pop one expected matrix and compare.
  logic done_d = 1'b0;
  int   bad, br, bc, be;
  always @(negedge I_CLK) begin
    if (O_DONE && !done_d) begin
      checks++;
      if (exp_q.size() < X_R * W_C) begin
        failures++;
        $display("FAIL done_unexpected: got done with %0d queued values expected %0d", exp_q.size(), X_R * W_C);
      end else begin
        bad = 0; br = 0; bc = 0; be = 0;
        for (int r = 0; r < X_R; r++)
          for (int c = 0; c < W_C; c++) begin
            be = exp_q.pop_front();
            if (int'(y[r][c]) != be) begin
              if (bad == 0) begin br = r; bc = c; end
              bad++;
            end
          end
        if (bad != 0) begin
          failures++;
          $display("FAIL matrix_at_done: %0d bad elements, first [%0d][%0d] got %0d", bad, br, bc, int'(y[br][bc]));
        end
      end
    end
    done_d = O_DONE;
  end

  task automatic do_start();
    I_START = 1'b1;
    @(negedge I_CLK);
    I_START = 1'b0;
    clear_model();
  endtask

  task automatic feed_phase(input int stray);
    for (int i = 0; i < stray; i++) begin
      I_SA_OUT_VLD = 1'b1;
      junk_row();
      @(negedge I_CLK);
    end
    I_FEED_OVER = 1'b1;
    @(negedge I_CLK);
    I_FEED_OVER = 1'b0;
    I_SA_OUT_VLD = 1'b0;
  endtask

  // mode 0: shift toggles 0,1,0,1...; mode 1: random shift pattern.
  task automatic flush_phase(input int mode, input bit stray, output int ncyc);
    int highs;
    int n;
    bit early;
    highs = 0; n = 0; early = 1'b0;
    while (highs < FLUSH_LEN && n < 1000) begin
      I_PE_SHIFT = (mode == 0) ? n[0] : 1'($urandom_range(0, 1));
      I_SA_OUT_VLD = stray;
      if (stray) junk_row();
      @(negedge I_CLK);
      highs += int'(I_PE_SHIFT);
      n++;
      if (highs < FLUSH_LEN && O_DRAIN_REQ) early = 1'b1;
    end
    I_PE_SHIFT = 1'b0;
    I_SA_OUT_VLD = 1'b0;
    chk("flush_no_early_drain", int'(early), 0);
    chk("drain_req_after_flush", int'(O_DRAIN_REQ), 1);
    ncyc = n;
  endtask

  // kind 0: row k all k; kind 1: random; kind 2: random with 300/-200 in row 0.
  task automatic drain_rows(input int nrows, input int kind, input bit gaps);
    int v;
    for (int k = 0; k < nrows; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        I_SA_OUT_VLD = 1'b0;
        junk_row();
        @(negedge I_CLK);
      end
      for (int c = 0; c < W_C; c++) begin
        if (kind == 0) v = k;
        else if (kind == 2 && k == 0 && c == 0) v = 300;
        else if (kind == 2 && k == 0 && c == 1) v = -200;
        else v = rand_acc();
        sa_row[c] = ACC_W'(v);
        exp_m[X_R-1-k][c] = narrow(v);
      end
      if (k == X_R - 1)
        for (int r = 0; r < X_R; r++)
          for (int c = 0; c < W_C; c++) exp_q.push_back(exp_m[r][c]);
      I_SA_OUT_VLD = 1'b1;
      @(negedge I_CLK);
    end
    I_SA_OUT_VLD = 1'b0;
    if (nrows == X_R) begin
      chk("done_after_last_row", int'(O_DONE), 1);
      chk("drain_req_off_in_done", int'(O_DRAIN_REQ), 0);
      chk("busy_off_in_done", int'(O_BUSY), 0);
    end else begin
      chk("still_draining", int'(O_DRAIN_REQ), 1);
    end
  endtask

  task automatic full_run(input int kind, input int mode, input bit stray, input bit gaps);
    int n;
    do_start();
    chk("start_matrix_zero", mat_zero(), 1);
    feed_phase(stray ? 2 : 0);
    flush_phase(mode, stray, n);
    drain_rows(X_R, kind, gaps);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int c = 0; c < W_C; c++) sa_row[c] = '0;
    clear_model();
    #1;
    chk("rst_busy", int'(O_BUSY), 0);
    chk("rst_done", int'(O_DONE), 0);
    chk("rst_drain_req", int'(O_DRAIN_REQ), 0);
    chk("rst_matrix_zero", mat_zero(), 1);
    @(negedge I_CLK);
    @(negedge I_CLK);
    I_ASYN_RSTN = 1'b1;
    I_SA_OUT_VLD = 1'b1;
    I_FEED_OVER = 1'b1;
    repeat (3) @(negedge I_CLK);
    I_SA_OUT_VLD = 1'b0;
    I_FEED_OVER = 1'b0;
    chk("idle_after_release", int'(O_BUSY), 0);
    chk("idle_matrix_zero", mat_zero(), 1);

    // Nominal run with stray valids and 0/1 toggling shift.
    do_start();
    chk("start_busy", int'(O_BUSY), 1);
    chk("start_done", int'(O_DONE), 0);
    feed_phase(3);
    chk("wait_feed_no_drain", int'(O_DRAIN_REQ), 0);
    flush_phase(0, 1'b1, n);
    chk("flush_gating_cycles", n, 2 * FLUSH_LEN);
    chk("stray_vld_matrix_zero", mat_zero(), 1);
    drain_rows(X_R, 0, 1'b0);
    chk("nominal_row0_bottom", int'(y[X_R-1][0]), 0);
    chk("nominal_row15_top", int'(y[0][W_C-1]), 15);

    // DONE holds against stray inputs.
    for (int i = 0; i < 4; i++) begin
      I_SA_OUT_VLD = 1'b1;
      I_FEED_OVER = 1'b1;
      I_PE_SHIFT = 1'b1;
      junk_row();
      @(negedge I_CLK);
    end
    I_SA_OUT_VLD = 1'b0;
    I_FEED_OVER = 1'b0;
    I_PE_SHIFT = 1'b0;
    chk("done_hold", int'(O_DONE), 1);
    chk("done_hold_matrix", mat_match(), 1);

    // Narrowing boundary values.
    full_run(2, 1, 1'b0, 1'b1);
    chk("narrow_pos_300", int'(y[X_R-1][0]), NARROW_POS);
    chk("narrow_neg_m200", int'(y[X_R-1][1]), NARROW_NEG);

    for (int i = 0; i < 3; i++) full_run(1, 1, 1'(i % 2), 1'b1);

    // Restart after 5 rows; START collides with a valid row and must win.
    do_start();
    feed_phase(0);
    flush_phase(1, 1'b0, n);
    drain_rows(5, 1, 1'b1);
    I_START = 1'b1;
    I_SA_OUT_VLD = 1'b1;
    junk_row();
    @(negedge I_CLK);
    I_START = 1'b0;
    I_SA_OUT_VLD = 1'b0;
    clear_model();
    chk("restart_matrix_zero", mat_zero(), 1);
    chk("restart_busy", int'(O_BUSY), 1);
    chk("restart_done", int'(O_DONE), 0);
    chk("restart_no_drain", int'(O_DRAIN_REQ), 0);
    feed_phase(1);
    flush_phase(1, 1'b1, n);
    drain_rows(X_R, 1, 1'b1);

    // Asynchronous reset in the middle of DRAIN.
    do_start();
    feed_phase(0);
    flush_phase(1, 1'b0, n);
    drain_rows(7, 1, 1'b0);
    I_SA_OUT_VLD = 1'b1;
    junk_row();
    #2;
    I_ASYN_RSTN = 1'b0;
    #1;
    chk("midrst_busy", int'(O_BUSY), 0);
    chk("midrst_drain_req", int'(O_DRAIN_REQ), 0);
    chk("midrst_done", int'(O_DONE), 0);
    chk("midrst_matrix_zero", mat_zero(), 1);
    @(negedge I_CLK);
    I_ASYN_RSTN = 1'b1;
    repeat (2) @(negedge I_CLK);
    I_SA_OUT_VLD = 1'b0;
    chk("post_rst_matrix_zero", mat_zero(), 1);
    chk("post_rst_idle", int'(O_BUSY), 0);
    do_start();
    chk("post_rst_start_busy", int'(O_BUSY), 1);
    feed_phase(0);
    flush_phase(1, 1'b0, n);
    drain_rows(X_R, 1, 1'b1);

    repeat (3) @(negedge I_CLK);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sa_result_collector.md
SA_RESULT_COLLECTOR -- requirements
Module: SA_result_collector

Interface
- REQ-001 The block SHALL have parameter D_W, default 8, meaning output element width (signed).
- REQ-002 The block SHALL have parameter ACC_W, default 24, meaning PE accumulator width (signed).
- REQ-003 The block SHALL have parameters X_R and W_C, default 16 each, meaning result rows and columns (array height and width).
- REQ-004 The block SHALL have port I_CLK, input, 1 bit, meaning clock; all state changes on its rising edge.
- REQ-005 The block SHALL have port I_ASYN_RSTN, input, 1 bit, meaning reset, asynchronous, active-low.
- REQ-006 The block SHALL have port I_START, input, 1 bit, meaning a synchronous arm and clear for a new matrix product.
- REQ-007 The block SHALL have port I_PE_SHIFT, input, 1 bit, meaning the array advance strobe shared with the input feeder.
- REQ-008 The block SHALL have port I_FEED_OVER, input, 1 bit, meaning the input feeder has presented its final vector.
- REQ-009 The block SHALL have port I_SA_OUT_VLD, input, 1 bit, meaning I_SA_ROW carries one drained result row this cycle.
- REQ-010 The block SHALL have port I_SA_ROW [ACC_W-1:0][0:W_C-1], input, meaning one accumulator row leaving the array.
- REQ-011 The block SHALL have port O_DRAIN_REQ, output, 1 bit, meaning a request that the array shift results out.
- REQ-012 The block SHALL have port O_Y_MATRIX [D_W-1:0][0:X_R-1][0:W_C-1], output, meaning the assembled result matrix.
- REQ-013 The block SHALL have port O_BUSY, output, 1 bit, meaning the FSM is not in IDLE or DONE.
- REQ-014 The block SHALL have port O_DONE, output, 1 bit, meaning the result matrix is complete and stable.

Function
- REQ-015 The FSM SHALL have states IDLE, WAIT_FEED, FLUSH, DRAIN and DONE.
- REQ-016 I_START in any state SHALL, on the next edge, enter WAIT_FEED, zero O_Y_MATRIX and zero the flush and row counters; I_START wins over every simultaneous event.
- REQ-017 In WAIT_FEED, I_FEED_OVER=1 SHALL move the FSM to FLUSH on the next edge.
- REQ-018 In FLUSH, the flush counter SHALL increment only on cycles with I_PE_SHIFT=1.
- REQ-019 When the flush counter reaches X_R+W_C-2 (30 at defaults), the FSM SHALL enter DRAIN; this covers the systolic skew latency.
- REQ-020 O_DRAIN_REQ SHALL be 1 exactly while in DRAIN.
- REQ-021 In DRAIN, each cycle with I_SA_OUT_VLD=1 SHALL write the narrowed I_SA_ROW into row X_R-1-rowcnt and increment rowcnt; the bottom row arrives first.
- REQ-022 After the X_R-th captured row, the FSM SHALL enter DONE on the same edge as that write.
- REQ-023 I_SA_OUT_VLD outside DRAIN SHALL be ignored, with no write and no counter change.
- REQ-024 Narrowing SHALL be per element from signed ACC_W to signed D_W, as selected in REQ-031 and REQ-032.
- REQ-025 O_DONE SHALL be 1 exactly while in DONE, and DONE SHALL be held until I_START.
- REQ-026 O_Y_MATRIX SHALL be registered and hold its value in DONE and in IDLE.
- REQ-027 I_FEED_OVER outside WAIT_FEED SHALL be ignored.

Reset
- REQ-028 Asserting I_ASYN_RSTN low SHALL immediately force state IDLE, all counters 0, O_Y_MATRIX all 0, and O_DRAIN_REQ, O_BUSY and O_DONE 0.
- REQ-029 Reset mid-DRAIN SHALL discard any partial result, and no write SHALL occur on the edge at which reset is released.
- REQ-030 After reset release, the block SHALL remain in IDLE until I_START.

Configuration
- REQ-031 With macro SA_COLLECT_SAT_EN defined, narrowing SHALL saturate to [-2^(D_W-1), 2^(D_W-1)-1] (-128..127 at defaults).
- REQ-032 Without SA_COLLECT_SAT_EN, narrowing SHALL keep bits [D_W-1:0] (two's-complement wrap).

Structure
- REQ-033 The state enum, the default parameter values and the flush-length expression (X_R+W_C-2) SHALL live in shared package SA_pkg.
- REQ-034 Per-element narrowing SHALL be one sub-module, SA_sat_trunc (ACC_W in, D_W out, combinational), instantiated W_C times.
- REQ-035 The FSM, counters and matrix register SHALL reside in SA_result_collector.

Verification
- REQ-036 The bench SHALL cover a nominal run: I_START, I_FEED_OVER, 30 I_PE_SHIFT pulses, then 16 valid rows where row k has all elements equal to k -> O_Y_MATRIX[15-k][*]==k, and O_DONE rises on the edge after the 16th row.
- REQ-037 The bench SHALL cover flush gating: I_PE_SHIFT toggling 1-0 in FLUSH -> DRAIN entered only after 30 high cycles, i.e. 60 cycles.
- REQ-038 The bench SHALL cover narrowing: an element of 300 and an element of -200 -> 127 and -128 with SA_COLLECT_SAT_EN; 44 and 56 without.
- REQ-039 The bench SHALL cover stray valid: I_SA_OUT_VLD=1 during WAIT_FEED and FLUSH -> O_Y_MATRIX remains all 0 and rowcnt remains 0.
- REQ-040 The bench SHALL cover restart: I_START after 5 drained rows -> matrix zeroed, state WAIT_FEED, O_DONE 0, and the next run completes correctly.
- REQ-041 The bench SHALL cover reset: I_ASYN_RSTN pulsed low mid-DRAIN -> all outputs 0 immediately and state IDLE; O_BUSY goes 0, then 1 after I_START.
